// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   - per-channel FSM state encoding
//   - captured operation encoding
//   - latency counter width
package mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel of the memory responder.
// This module accepts a read or write request, counts out the fixed latency and
// pulses the matching ready for one cycle. It then waits for the served valid
// to drop, so that a request which is still held is not served a second time.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request; a read wins over a write
//   BUSY  | latency countdown; inputs ignored
//   RESP  | ready pulse; write commits on the edge leaving this state
//   DROP  | waiting for the served valid to go low
//
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   read_valid_i / read_address_i  read request from the master
//   write_valid_i / write_address_i / write_data_i   write request from the master
//   read_ready_o, write_ready_o    one-cycle response pulses
//   rd_sample_o, rd_addr_o         the array is sampled for this channel on this edge
//   wr_commit_o, wr_addr_o, wr_data_o   commit the captured write on this edge
module mem_responder_channel
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int LATENCY   = 2,
    parameter int WRITABLE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid_i,
    input  logic [ADDR_BITS-1:0] read_address_i,
    input  logic                 write_valid_i,
    input  logic [ADDR_BITS-1:0] write_address_i,
    input  logic [DATA_BITS-1:0] write_data_i,
    output logic                 read_ready_o,
    output logic                 write_ready_o,
    output logic                 rd_sample_o,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    output logic                 wr_commit_o,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    output logic [DATA_BITS-1:0] wr_data_o
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    op_e                    op_q, op_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;

    logic wr_req;
    logic served_valid;

    assign wr_req       = (WRITABLE != 0) && write_valid_i;
    assign served_valid = (op_q == READ) ? read_valid_i : wr_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (read_valid_i) begin
                    op_d    = READ;
                    addr_d  = read_address_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end else if (wr_req) begin
                    op_d    = WRITE;
                    addr_d  = write_address_i;
                    data_d  = write_data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // The counter reaches 0 on this edge when it holds 1 now.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: state_d = DROP;
            DROP: begin
                if (!served_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= READ;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign read_ready_o  = (state_q == RESP) && (op_q == READ);
    assign write_ready_o = (state_q == RESP) && (op_q == WRITE);

    // Read data is registered on the edge that enters RESP. That edge sees the
    // array as it was before the edge, so a same-edge write is not visible.
    assign rd_sample_o = reset && (state_d == RESP) && (op_d == READ);
    assign rd_addr_o   = addr_d;

    assign wr_commit_o = reset && (state_q == RESP) && (op_q == WRITE);
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel memory responder: a word-addressed array served by
// NUM_CHANNELS independent valid/ready channels, plus a backdoor load port.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   read_valid/read_address         per-channel read requests (packed)
//   read_ready/read_data            per-channel read response pulse and data
//   write_valid/write_address/write_data   per-channel write requests (packed)
//   write_ready                     per-channel write-complete pulse
//   load_enable/load_address/load_data     backdoor array write
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2,
    parameter int WRITABLE     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CHANNELS-1:0]        read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]        read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]        write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]        write_ready,
    input  logic                           load_enable,
    input  logic [ADDR_BITS-1:0]           load_address,
    input  logic [DATA_BITS-1:0]           load_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic [NUM_CHANNELS-1:0] rd_sample;
    logic [ADDR_BITS-1:0]    rd_addr [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wr_commit;
    logic [ADDR_BITS-1:0]    wr_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_data [NUM_CHANNELS];

    logic [NUM_CHANNELS*DATA_BITS-1:0] read_data_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mem_responder_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY),
            .WRITABLE  (WRITABLE)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .read_valid_i    (read_valid[c]),
            .read_address_i  (read_address[c*ADDR_BITS +: ADDR_BITS]),
            .write_valid_i   (write_valid[c]),
            .write_address_i (write_address[c*ADDR_BITS +: ADDR_BITS]),
            .write_data_i    (write_data[c*DATA_BITS +: DATA_BITS]),
            .read_ready_o    (read_ready[c]),
            .write_ready_o   (write_ready[c]),
            .rd_sample_o     (rd_sample[c]),
            .rd_addr_o       (rd_addr[c]),
            .wr_commit_o     (wr_commit[c]),
            .wr_addr_o       (wr_addr[c]),
            .wr_data_o       (wr_data[c])
        );
    end

    // Array contents are not reset. When writes collide, the last assignment
    // wins, so channels are applied from highest to lowest and the load port last.
    always_ff @(posedge clk) begin
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (wr_commit[c]) mem_q[wr_addr[c]] <= wr_data[c];
        end
        if (load_enable) mem_q[load_address] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (rd_sample[c]) read_data_q[c*DATA_BITS +: DATA_BITS] <= mem_q[rd_addr[c]];
            end
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (default parameters, LATENCY=2).
module tb_mem_responder;

    localparam int A   = 8;
    localparam int D   = 8;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   read_valid, read_ready, write_valid, write_ready;
    logic [N*A-1:0] read_address, write_address;
    logic [N*D-1:0] read_data, write_data;
    logic           load_enable;
    logic [A-1:0]   load_address;
    logic [D-1:0]   load_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .ADDR_BITS(A), .DATA_BITS(D), .NUM_CHANNELS(N), .LATENCY(LAT), .WRITABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready),
        .load_enable(load_enable), .load_address(load_address), .load_data(load_data)
    );

    typedef struct {
        int         ch;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_enable  = 1'b1;
        load_address = a;
        load_data    = d;
        tick();
        load_enable  = 1'b0;
    endtask

    function automatic logic [7:0] rdata(input int ch);
        return read_data[ch*D +: D];
    endfunction

    task automatic set_rd(input int ch, input logic [7:0] a);
        read_address[ch*A +: A] = a;
        read_valid[ch] = 1'b1;
    endtask

    task automatic set_wr(input int ch, input logic [7:0] a, input logic [7:0] d);
        write_address[ch*A +: A] = a;
        write_data[ch*D +: D]    = d;
        write_valid[ch] = 1'b1;
    endtask

    // Single transaction; the valid is dropped in the response cycle.
    task automatic txn(input string name, input int ch, input bit wr,
                       input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
        logic [3:0] one;
        one = 4'b0001;
        if (wr) set_wr(ch, a, d);
        else    set_rd(ch, a);
        tick();
        chk({name, "_busy_rdy"}, {read_ready, write_ready}, 8'h00);
        tick();
        if (wr) chk({name, "_resp_rdy"}, {read_ready, write_ready}, {4'b0, one << ch});
        else    chk({name, "_resp_rdy"}, {read_ready, write_ready}, {one << ch, 4'b0});
        if (!wr) chk({name, "_data"}, rdata(ch), exp);
        read_valid  = '0;
        write_valid = '0;
        tick();
        chk({name, "_drop_rdy"}, {read_ready, write_ready}, 8'h00);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cnt;
        bit  found;

        vecs[0] = '{ch: 0, wr: 0, addr: 8'h10, data: 8'h00, exp: 8'h2A};
        vecs[1] = '{ch: 1, wr: 1, addr: 8'h21, data: 8'h66, exp: 8'h00};
        vecs[2] = '{ch: 2, wr: 0, addr: 8'h21, data: 8'h00, exp: 8'h66};
        vecs[3] = '{ch: 3, wr: 0, addr: 8'hFF, data: 8'h00, exp: 8'hA5};
        vecs[4] = '{ch: 3, wr: 1, addr: 8'hFF, data: 8'hC3, exp: 8'h00};
        vecs[5] = '{ch: 0, wr: 0, addr: 8'hFF, data: 8'h00, exp: 8'hC3};
        vecs[6] = '{ch: 1, wr: 0, addr: 8'h00, data: 8'h00, exp: 8'h5A};
        vecs[7] = '{ch: 2, wr: 1, addr: 8'h00, data: 8'h01, exp: 8'h00};
        vecs[8] = '{ch: 2, wr: 0, addr: 8'h00, data: 8'h00, exp: 8'h01};

        reset = 1'b0;
        read_valid = '0; write_valid = '0;
        read_address = '0; write_address = '0; write_data = '0;
        load_enable = 1'b0; load_address = '0; load_data = '0;
        tick();

        // Preload the array; the load port works while the FSMs are held in reset.
        load(8'h10, 8'h2A); load(8'h11, 8'h3B); load(8'h12, 8'h4C); load(8'h13, 8'h5D);
        load(8'h40, 8'h07); load(8'hFF, 8'hA5); load(8'h00, 8'h5A); load(8'h60, 8'h01);
        load(8'h70, 8'h0E);

        chk("reset_ready", {read_ready, write_ready}, 8'h00);
        chk("reset_rdata", read_data, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
        end

        // A write whose valid is held 3 cycles past ready pulses ready only once.
        set_wr(1, 8'h20, 8'h55);
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (write_ready[1]) cnt++;
            if (k == 5) write_valid[1] = 1'b0;
        end
        chk("held_write_pulses", cnt, 1);
        txn("held_write_readback", 0, 0, 8'h20, 8'h00, 8'h55);

        // Channels 0 and 2 write the same address on the same edge.
        set_wr(0, 8'h30, 8'h11);
        set_wr(2, 8'h30, 8'h22);
        tick(); tick();
        chk("dual_write_ready", write_ready, 4'b0101);
        write_valid = '0;
        tick(); tick();
        txn("dual_write_readback", 1, 0, 8'h30, 8'h00, 8'h11);

        // All four channels read at once.
        for (int c = 0; c < N; c++) set_rd(c, 8'h10 + 8'(c));
        tick(); tick();
        chk("all_read_ready", read_ready, 4'hF);
        chk("all_read_d0", rdata(0), 8'h2A);
        chk("all_read_d1", rdata(1), 8'h3B);
        chk("all_read_d2", rdata(2), 8'h4C);
        chk("all_read_d3", rdata(3), 8'h5D);
        read_valid = '0;
        tick(); tick();

        // Read and write both valid on channel 3: the read goes first.
        set_rd(3, 8'h12);
        set_wr(3, 8'h50, 8'h77);
        tick(); tick();
        chk("rw_first_ready", {read_ready[3], write_ready[3]}, 2'b10);
        chk("rw_first_data", rdata(3), 8'h4C);
        read_valid[3] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (write_ready[3]) found = 1'b1;
        end
        chk("rw_second_write_ready", found, 1'b1);
        write_valid[3] = 1'b0;
        tick(); tick();
        txn("rw_write_readback", 0, 0, 8'h50, 8'h00, 8'h77);

        // Reset while a write to 0x40 is in BUSY.
        set_wr(2, 8'h40, 8'h99);
        tick();
        reset = 1'b0;
        write_valid = '0;
        tick();
        chk("rst_busy_ready", {read_ready, write_ready}, 8'h00);
        chk("rst_busy_rdata", read_data, 32'h0);
        tick();
        chk("rst_busy_ready2", {read_ready, write_ready}, 8'h00);
        reset = 1'b1;
        tick(); tick();
        txn("rst_write_dropped", 1, 0, 8'h40, 8'h00, 8'h07);

        // Write commit and read sample on the same edge: the read sees the old word.
        set_wr(1, 8'h60, 8'h99);
        tick();
        set_rd(0, 8'h60);
        tick();
        chk("same_edge_wr_ready", write_ready, 4'b0010);
        write_valid = '0;
        tick();
        chk("same_edge_rd_ready", read_ready, 4'b0001);
        chk("same_edge_old_word", rdata(0), 8'h01);
        read_valid = '0;
        tick(); tick();
        txn("same_edge_new_word", 2, 0, 8'h60, 8'h00, 8'h99);

        // A load on the accept edge is visible to a read that samples on the next edge.
        load_enable = 1'b1; load_address = 8'h70; load_data = 8'hEE;
        set_rd(1, 8'h70);
        tick();
        load_enable = 1'b0;
        tick();
        chk("load_vis_ready", read_ready, 4'b0010);
        chk("load_vis_data", rdata(1), 8'hEE);
        read_valid = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
